// File: rtl/sram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter_if
// Brief    : Request/response bundle between two requesters (port 0 = fetch,
//            port 1 = data) and the SRAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface sram_arbiter_if #(
   parameter int WORDSIZE = 64,
   parameter int WIDTH    = 512,
   parameter int LOGDEPTH = 9
);
   localparam int NWORDS = WIDTH / WORDSIZE;

   logic [1:0]          req_valid;
   logic [1:0]          req_ready;
   logic [1:0]          req_write;
   logic [LOGDEPTH-1:0] req_addr  [2];
   logic [WIDTH-1:0]    req_wdata [2];
   logic [NWORDS-1:0]   req_wmask [2];
   logic [1:0]          rsp_valid;
   logic [WIDTH-1:0]    rsp_data;

   // Requester side.
   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_wmask,
      input  req_ready, rsp_valid, rsp_data
   );

   // Arbiter side.
   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_wmask,
      output req_ready, rsp_valid, rsp_data
   );
endinterface
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter
// Brief    : Two-port read/write arbiter and sequencer for a single SRAM.
//            Reads and writes arbitrate independently; granted reads are
//            tracked by a READ_LAT-deep tag pipeline that steers each
//            response back to its owner.
// Config   : SRAM_ARB_FIXED_PRIO_EN - port 0 always wins contention
//            (default: per-class round-robin).
// Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
   parameter int WORDSIZE = 64,
   parameter int WIDTH    = 512,
   parameter int LOGDEPTH = 9,
   parameter int READ_LAT = 1
) (
   input  wire logic                    clk,
   input  wire logic                    reset_n,
   sram_arbiter_if.slave                bus,
   input  wire logic [WIDTH-1:0]        sram_readData,
   output logic [LOGDEPTH-1:0]          sram_readAddr,
   output logic [LOGDEPTH-1:0]          sram_writeAddr,
   output logic [WIDTH-1:0]             sram_writeData,
   output logic [WIDTH/WORDSIZE-1:0]    sram_writeEnable
);
   localparam int c_NWORDS = WIDTH / WORDSIZE;

   logic [1:0]          w_rdReq, w_wrReq;
   logic [1:0]          w_rdGrant, w_wrGrant;
   logic                w_rdWin, w_wrWin;
   logic                w_rdFav, w_wrFav;
   logic                w_rdAny, w_wrAny;
   logic [LOGDEPTH-1:0] r_rdAddr, r_wrAddr;
   logic [WIDTH-1:0]    r_wrData;
   logic [READ_LAT-1:0] r_tagValid, r_tagPort;
   logic [READ_LAT-1:0] w_tagValidNext, w_tagPortNext;

`ifdef SRAM_ARB_FIXED_PRIO_EN
   assign w_rdFav = 1'b0;
   assign w_wrFav = 1'b0;
`else
   logic r_rdPri, r_wrPri;

   // Round-robin state: after a contested grant the loser is favoured next.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_rdPri <= 1'b0;
         r_wrPri <= 1'b0;
      end else begin
         if (&w_rdReq) r_rdPri <= ~w_rdWin;
         if (&w_wrReq) r_wrPri <= ~w_wrWin;
      end
   end

   assign w_rdFav = r_rdPri;
   assign w_wrFav = r_wrPri;
`endif

   // Split requests into read/write classes and pick one winner per class.
   always_comb begin
      w_rdReq   = reset_n ? (bus.req_valid & ~bus.req_write) : 2'b00;
      w_wrReq   = reset_n ? (bus.req_valid &  bus.req_write) : 2'b00;
      w_rdAny   = |w_rdReq;
      w_wrAny   = |w_wrReq;
      w_rdWin   = (&w_rdReq) ? w_rdFav : w_rdReq[1];
      w_wrWin   = (&w_wrReq) ? w_wrFav : w_wrReq[1];
      w_rdGrant = 2'b00;
      w_wrGrant = 2'b00;
      if (w_rdAny) w_rdGrant[w_rdWin] = 1'b1;
      if (w_wrAny) w_wrGrant[w_wrWin] = 1'b1;
   end

   assign bus.req_ready = w_rdGrant | w_wrGrant;

   // SRAM pins follow the winners in the grant cycle; addresses hold otherwise.
   always_comb begin
      sram_readAddr    = r_rdAddr;
      sram_writeAddr   = r_wrAddr;
      sram_writeData   = r_wrData;
      sram_writeEnable = {c_NWORDS{1'b0}};
      if (w_rdAny) sram_readAddr = bus.req_addr[w_rdWin];
      if (w_wrAny) begin
         sram_writeAddr   = bus.req_addr[w_wrWin];
         sram_writeData   = bus.req_wdata[w_wrWin];
         sram_writeEnable = bus.req_wmask[w_wrWin];
      end
   end

   // Remember the last driven addresses/data so idle cycles keep them stable.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_rdAddr <= '0;
         r_wrAddr <= '0;
         r_wrData <= '0;
      end else begin
         if (w_rdAny) r_rdAddr <= bus.req_addr[w_rdWin];
         if (w_wrAny) begin
            r_wrAddr <= bus.req_addr[w_wrWin];
            r_wrData <= bus.req_wdata[w_wrWin];
         end
      end
   end

   // Tag pipeline next state: new tag enters stage 0, older tags shift up.
   generate
      if (READ_LAT == 1) begin : g_tagLat1
         assign w_tagValidNext = w_rdAny;
         assign w_tagPortNext  = w_rdWin;
      end else begin : g_tagLatN
         assign w_tagValidNext = {r_tagValid[READ_LAT-2:0], w_rdAny};
         assign w_tagPortNext  = {r_tagPort[READ_LAT-2:0],  w_rdWin};
      end
   endgenerate

   // Tag pipeline register; reset drops every read still in flight.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_tagValid <= '0;
         r_tagPort  <= '0;
      end else begin
         r_tagValid <= w_tagValidNext;
         r_tagPort  <= w_tagPortNext;
      end
   end

   assign bus.rsp_valid = (reset_n && r_tagValid[READ_LAT-1])
                        ? (r_tagPort[READ_LAT-1] ? 2'b10 : 2'b01) : 2'b00;
   assign bus.rsp_data  = sram_readData;

endmodule
`default_nettype wire
